reset_tick_seq: RTL and testbench
=================================

// Module: reset_tick_seq
// PURPOSE
//  Parametrised lock-qualified reset sequencer and multi-channel tick generator for the PLL clock domain.
//  Filters PLL lock, holds a synchronous-release system reset, re-sequences on lock loss or soft request.
//  Emits NUM_TICKS divided strobe channels plus a free-running heartbeat for the status LED.
//  Sits directly after the PLL/BUFG wrapper; all downstream logic consumes rst_out and tick[].
// PARAMETERS
//  LOCK_FILTER   16          consecutive synced-lock cycles required before HOLD (>=1)
//  RESET_CYCLES  64          cycles rst_out stays high after filter passes (>=1)
//  NUM_TICKS     3           number of tick channels (1..8)
//  TICK_DIV      {32'd48000,32'd48,32'd1}  packed NUM_TICKS*32; channel i divisor = TICK_DIV[32*i+:32]
//  HB_BIT        23          heartbeat counter bit driven to heartbeat (counter width HB_BIT+1)
// PORTS
//  clk            in   1            PLL output clock (post-BUFG)
//  reset          in   1            async active-high; clears all state
//  pll_locked     in   1            PLL LOCKED, asynchronous to clk
//  soft_rst_req   in   1            sync pulse: re-run HOLD phase
//  lock_lost_clr  in   1            sync pulse: clear lock_lost (and loss_count)
//  rst_out        out  1            system reset, registered, high in every state except RUN
//  tick           out  NUM_TICKS    one-cycle strobes, channel i every TICK_DIV[i] cycles in RUN
//  heartbeat      out  1            hb_cnt[HB_BIT]
//  lock_lost      out  1            sticky: lock dropped while in RUN
//  seq_state      out  2            current state encoding (debug)
//  loss_count     out  8            only with RESET_SEQ_LOSS_COUNT_EN
// BEHAVIOUR
//  Reset values: rst_out=1, tick=0, heartbeat=0, lock_lost=0, seq_state=WAIT_LOCK, loss_count=0, sync flops=0.
//  pll_locked -> 2-flop synchroniser -> locked_s; only locked_s is used internally.
//  FSM: WAIT_LOCK(0) -> FILTER(1) when locked_s=1, cnt<=0.
//   FILTER: cnt++ while locked_s; cnt==LOCK_FILTER-1 -> HOLD, cnt<=0; locked_s=0 -> WAIT_LOCK.
//   HOLD(2): cnt++; cnt==RESET_CYCLES-1 -> RUN(3); locked_s=0 -> WAIT_LOCK.
//   RUN: locked_s=0 -> WAIT_LOCK, set lock_lost; soft_rst_req -> HOLD, cnt<=0.
//   soft_rst_req in HOLD restarts cnt at 0; ignored in WAIT_LOCK/FILTER.
//   Simultaneous lock loss + soft_rst_req: lock loss wins.
//  rst_out registered from next-state: changes on the same edge as seq_state.
//  Latency: pll_locked rising before edge p -> rst_out falls at edge p+2+LOCK_FILTER+RESET_CYCLES.
//   pll_locked falling before edge k -> rst_out rises at edge k+2 (from HOLD or RUN).
//  Ticks: per-channel counter, held 0 outside RUN; in RUN counts 0..DIV-1, tick=1 on cycle counter==DIV-1,
//   then wraps to 0. First tick DIV cycles after entering RUN. DIV=1 -> tick high every RUN cycle.
//   DIV=0 -> channel disabled, tick held 0. Counter width $clog2(max DIV+1), no overflow.
//  Heartbeat: hb_cnt free-runs in all states, wraps at 2^(HB_BIT+1); cleared only by reset.
//  lock_lost: set beats clear when both occur in one cycle.
//  Async reset mid-sequence: immediate return to reset values; sequence restarts from WAIT_LOCK.
// CONFIGURATION
//  RESET_SEQ_LOSS_COUNT_EN defined: loss_count port present; increments (saturating at 255) on each
//   RUN->WAIT_LOCK transition; cleared by lock_lost_clr (increment wins if same cycle).
//  Undefined: loss_count port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package reset_tick_pkg: seq_state_t enum {WAIT_LOCK=2'd0,FILTER=2'd1,HOLD=2'd2,RUN=2'd3},
//   MAX_TICKS=8, LOSS_CNT_W=8.
//  Sub-module tick_divider (param DIV): enable, count, one-cycle strobe; generate-instanced per channel.
// TESTING
//  LOCK_FILTER=4,RESET_CYCLES=8: pll_locked rises before edge 10 -> rst_out falls exactly at edge 24.
//  pll_locked glitches low 1 cycle during FILTER -> FSM back to WAIT_LOCK, rst_out stays 1, full filter rerun.
//  In RUN drop pll_locked before edge k -> rst_out=1 at k+2, lock_lost=1; lock_lost_clr pulse -> 0.
//  TICK_DIV={0,3,1} in RUN for 12 cycles -> ch0 high 12/12, ch1 pulses on cycles 3,6,9,12, ch2 never.
//  soft_rst_req and lock loss same cycle in RUN -> WAIT_LOCK chosen; soft_rst_req alone -> rst_out high 8 cycles.
//  With RESET_SEQ_LOSS_COUNT_EN: 300 lock-loss cycles from RUN -> loss_count saturates at 255.

Source files
------------

// File: rtl/reset_tick_pkg.sv
// Shared types and helpers for the reset sequencer and its tick dividers.
package reset_tick_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      FILTER    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } seq_state_t;

   localparam int MAX_TICKS  = 8;
   localparam int LOSS_CNT_W = 8;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_width(input int unsigned max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/reset_tick_seq_divider.sv
// One tick channel: counts 0..DIV-1 while enabled and strobes on the last count.
// DIV=0 leaves the counter parked at zero and the strobe low.
module tick_divider
   import reset_tick_pkg::*;
#(
   parameter int unsigned DIV = 1
)(
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic strobe
);

   localparam int            CW     = cnt_width(DIV);
   localparam bit            ACTIVE = (DIV != 0);
   localparam logic [CW-1:0] LAST   = CW'(DIV - 1);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;

   always_comb begin
      cnt_next = '0;
      if (ACTIVE && enable) begin
         cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign strobe = ACTIVE && enable && (cnt_reg == LAST);

endmodule

// File: rtl/reset_tick_seq.sv
// Lock-qualified reset sequencer with divided tick channels and a heartbeat.
// Optional build macro RESET_SEQ_LOSS_COUNT_EN adds the saturating loss_count output.
module reset_tick_seq
   import reset_tick_pkg::*;
#(
   parameter int unsigned               LOCK_FILTER  = 16,
   parameter int unsigned               RESET_CYCLES = 64,
   parameter int unsigned               NUM_TICKS    = 3,
   parameter logic [NUM_TICKS*32-1:0]   TICK_DIV     = {32'd48000, 32'd48, 32'd1},
   parameter int unsigned               HB_BIT       = 23
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pll_locked,
   input  logic                  soft_rst_req,
   input  logic                  lock_lost_clr,
   output logic                  rst_out,
   output logic [NUM_TICKS-1:0]  tick,
   output logic                  heartbeat,
   output logic                  lock_lost,
   output logic [1:0]            seq_state
`ifdef RESET_SEQ_LOSS_COUNT_EN
   ,
   output logic [LOSS_CNT_W-1:0] loss_count
`endif
);

   localparam int unsigned CNT_MAX = (LOCK_FILTER > RESET_CYCLES) ? LOCK_FILTER : RESET_CYCLES;
   localparam int          CNT_W   = cnt_width(CNT_MAX);
   localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_CYCLES - 1);

   logic             sync1_reg;
   logic             locked_s_reg;
   seq_state_t       state_reg;
   seq_state_t       state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             rst_out_reg;
   logic             lock_lost_reg;
   logic             lock_lost_next;
   logic             lock_drop;
   logic [HB_BIT:0]  hb_cnt_reg;
   logic             run_en;

   // pll_locked is asynchronous to clk; only the second stage feeds the FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg    <= 1'b0;
         locked_s_reg <= 1'b0;
      end else begin
         sync1_reg    <= pll_locked;
         locked_s_reg <= sync1_reg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= WAIT_LOCK;
         cnt_reg       <= '0;
         rst_out_reg   <= 1'b1;
         lock_lost_reg <= 1'b0;
         hb_cnt_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         rst_out_reg   <= (state_next != RUN);
         lock_lost_reg <= lock_lost_next;
         hb_cnt_reg    <= hb_cnt_reg + 1'b1;
      end
   end

   // Lock loss is tested first in every state so it always beats soft_rst_req.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      lock_drop  = 1'b0;
      case (state_reg)
         WAIT_LOCK: begin
            if (locked_s_reg) begin
               state_next = FILTER;
               cnt_next   = '0;
            end
         end
         FILTER: begin
            if (!locked_s_reg) begin
               state_next = WAIT_LOCK;
            end else if (cnt_reg == FILTER_LAST) begin
               state_next = HOLD;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         HOLD: begin
            if (!locked_s_reg) begin
               state_next = WAIT_LOCK;
            end else if (soft_rst_req) begin
               cnt_next = '0;
            end else if (cnt_reg == HOLD_LAST) begin
               state_next = RUN;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         RUN: begin
            if (!locked_s_reg) begin
               state_next = WAIT_LOCK;
               lock_drop  = 1'b1;
            end else if (soft_rst_req) begin
               state_next = HOLD;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = WAIT_LOCK;
         end
      endcase
   end

   always_comb begin
      lock_lost_next = lock_lost_reg;
      if (lock_drop) begin
         lock_lost_next = 1'b1;
      end else if (lock_lost_clr) begin
         lock_lost_next = 1'b0;
      end
   end

`ifdef RESET_SEQ_LOSS_COUNT_EN
   logic [LOSS_CNT_W-1:0] loss_cnt_reg;
   logic [LOSS_CNT_W-1:0] loss_cnt_next;

   always_comb begin
      loss_cnt_next = loss_cnt_reg;
      if (lock_drop) begin
         if (loss_cnt_reg != '1) begin
            loss_cnt_next = loss_cnt_reg + 1'b1;
         end
      end else if (lock_lost_clr) begin
         loss_cnt_next = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         loss_cnt_reg <= '0;
      end else begin
         loss_cnt_reg <= loss_cnt_next;
      end
   end

   assign loss_count = loss_cnt_reg;
`endif

   assign run_en = (state_reg == RUN);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_TICKS; gi++) begin : g_tick
         tick_divider #(
            .DIV (TICK_DIV[32*gi +: 32])
         ) u_div (
            .clk    (clk),
            .reset  (reset),
            .enable (run_en),
            .strobe (tick[gi])
         );
      end
   endgenerate

   assign rst_out   = rst_out_reg;
   assign heartbeat = hb_cnt_reg[HB_BIT];
   assign lock_lost = lock_lost_reg;
   assign seq_state = state_reg;

endmodule

// File: tb/tb_reset_tick_seq.sv
// Directed bench for reset_tick_seq with LOCK_FILTER=4, RESET_CYCLES=8, TICK_DIV={0,3,1}, HB_BIT=3.
// Define RESET_SEQ_LOSS_COUNT_EN to also exercise loss_count saturation.
module tb_reset_tick_seq;

   localparam int NT = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          pll_locked;
   logic          soft_rst_req;
   logic          lock_lost_clr;
   logic          rst_out;
   logic [NT-1:0] tick;
   logic          heartbeat;
   logic          lock_lost;
   logic [1:0]    seq_state;
`ifdef RESET_SEQ_LOSS_COUNT_EN
   logic [7:0]    loss_count;
`endif

   int checks   = 0;
   int errors   = 0;
   int edge_num = 0;

   always #5 clk = ~clk;

   reset_tick_seq #(
      .LOCK_FILTER  (4),
      .RESET_CYCLES (8),
      .NUM_TICKS    (NT),
      .TICK_DIV     ({32'd0, 32'd3, 32'd1}),
      .HB_BIT       (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .pll_locked    (pll_locked),
      .soft_rst_req  (soft_rst_req),
      .lock_lost_clr (lock_lost_clr),
      .rst_out       (rst_out),
      .tick          (tick),
      .heartbeat     (heartbeat),
      .lock_lost     (lock_lost),
      .seq_state     (seq_state)
`ifdef RESET_SEQ_LOSS_COUNT_EN
      ,
      .loss_count    (loss_count)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edge_num++;
   endtask

   // rst_out, tick and heartbeat for the current edge, given the edge at which RUN starts.
   task automatic check_outs(input int run_edge);
      logic [2:0] te;
      int         j;
      te = 3'b000;
      if (edge_num >= run_edge) begin
         j  = edge_num - run_edge + 1;
         te = {1'b0, (j % 3 == 0), 1'b1};
      end
      check_val($sformatf("rst_out@%0d", edge_num), rst_out, edge_num < run_edge);
      check_val($sformatf("tick@%0d", edge_num), tick, te);
      check_val($sformatf("heartbeat@%0d", edge_num), heartbeat, (edge_num % 16) >= 8);
   endtask

   task automatic wait_state(input logic [1:0] target, input int budget);
      int n;
      n = 0;
      while (seq_state !== target && n < budget) begin
         step();
         n++;
      end
      if (seq_state !== target) check_val("wait_state_timeout", seq_state, target);
   endtask

   initial begin
      reset         = 1'b1;
      pll_locked    = 1'b0;
      soft_rst_req  = 1'b0;
      lock_lost_clr = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_val("reset_rst_out", rst_out, 1);
      check_val("reset_tick", tick, 0);
      check_val("reset_heartbeat", heartbeat, 0);
      check_val("reset_lock_lost", lock_lost, 0);
      check_val("reset_state", seq_state, 0);
`ifdef RESET_SEQ_LOSS_COUNT_EN
      check_val("reset_loss_count", loss_count, 0);
`endif
      @(negedge clk);
      reset    = 1'b0;
      edge_num = 0;

      // Power-up: lock rises before edge 10, rst_out must fall at edge 24.
      while (edge_num < 9) begin
         step();
         check_outs(24);
      end
      check_val("idle_state@9", seq_state, 0);
      pll_locked = 1'b1;
      while (edge_num < 35) begin
         step();
         check_outs(24);
         case (edge_num)
            11: check_val("state@11", seq_state, 0);
            12: check_val("state@12", seq_state, 1);
            15: check_val("state@15", seq_state, 1);
            16: check_val("state@16", seq_state, 2);
            23: check_val("state@23", seq_state, 2);
            24: check_val("state@24", seq_state, 3);
            default: ;
         endcase
      end

      // Soft reset from RUN: HOLD for 8 cycles, back in RUN at edge 44.
      soft_rst_req = 1'b1;
      step();
      soft_rst_req = 1'b0;
      check_val("soft_state@36", seq_state, 2);
      check_outs(44);
      while (edge_num < 46) begin
         step();
         check_outs(44);
      end
      check_val("soft_run@46", seq_state, 3);

      // Lock drops before edge 47; soft request lands on the same cycle the loss is seen.
      pll_locked = 1'b0;
      step();
      check_val("loss_rst@47", rst_out, 0);
      step();
      check_val("loss_state@48", seq_state, 3);
      soft_rst_req = 1'b1;
      step();
      soft_rst_req = 1'b0;
      check_val("loss_state@49", seq_state, 0);
      check_val("loss_rst@49", rst_out, 1);
      check_val("loss_tick@49", tick, 0);
      check_val("lock_lost@49", lock_lost, 1);
      step();
      check_val("lock_lost@50", lock_lost, 1);
`ifdef RESET_SEQ_LOSS_COUNT_EN
      check_val("loss_count@50", loss_count, 1);
`endif
      lock_lost_clr = 1'b1;
      step();
      lock_lost_clr = 1'b0;
      check_val("lock_lost_clr@51", lock_lost, 0);
`ifdef RESET_SEQ_LOSS_COUNT_EN
      check_val("loss_count_clr@51", loss_count, 0);
`endif

      // One-cycle glitch during FILTER: last rise before edge 54, so RUN at edge 68.
      pll_locked = 1'b1;
      step();
      pll_locked = 1'b0;
      step();
      pll_locked = 1'b1;
      while (edge_num < 72) begin
         step();
         check_outs(68);
         case (edge_num)
            54: check_val("glitch_state@54", seq_state, 1);
            55: check_val("glitch_state@55", seq_state, 0);
            56: check_val("glitch_state@56", seq_state, 1);
            60: check_val("glitch_state@60", seq_state, 2);
            68: check_val("glitch_state@68", seq_state, 3);
            default: ;
         endcase
      end

      // Asynchronous reset mid-cycle while in RUN with heartbeat high.
      #2;
      reset = 1'b1;
      #1;
      check_val("async_rst_out", rst_out, 1);
      check_val("async_state", seq_state, 0);
      check_val("async_tick", tick, 0);
      check_val("async_heartbeat", heartbeat, 0);
      @(negedge clk);
      reset    = 1'b0;
      edge_num = 0;
      while (edge_num < 18) begin
         step();
         check_outs(15);
         if (edge_num == 2) check_val("restart_state@2", seq_state, 0);
         if (edge_num == 3) check_val("restart_state@3", seq_state, 1);
      end

`ifdef RESET_SEQ_LOSS_COUNT_EN
      check_val("loss_count_pre", loss_count, 0);
      for (int i = 0; i < 300; i++) begin
         pll_locked = 1'b0;
         wait_state(2'd0, 20);
         pll_locked = 1'b1;
         wait_state(2'd3, 40);
      end
      check_val("loss_count_sat", loss_count, 255);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
